rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Circular reorder buffer that allocates in-order tags at dispatch and captures out-of-order results from the common data bus (CDB).
- Retires entries strictly in program order and drives the register file's write port: ROBwriteEnable, ROBwriteIndex, ROBwriteData.
- The register file samples that port on the rising edge of ROBwriteEnable. This block therefore guarantees a low phase between consecutive commit pulses.

Parameters:
- DEPTH, 8: number of ROB entries (power of two).
- TAG_W, 3: tag width; must equal log2(DEPTH).
- DATA_W, 32: result data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- allocValid  in  1  dispatch requests a new entry.
- allocDest  in  5  destination architectural register.
- allocWritesReg  in  1  instruction writes a register (0 for store, branch, fence).
- allocReady  out  1  entry available; equals !full.
- allocTag  out  TAG_W  tag that will be given to the current request; equals tail.
- cdbValid  in  1  result broadcast valid.
- cdbTag  in  TAG_W  tag of the broadcast result.
- cdbData  in  DATA_W  broadcast result value.
- flush  in  1  mispredict or exception; discard all entries.
- ROBwriteEnable  out  1  register-file write strobe, registered.
- ROBwriteIndex  out  5  register-file write index, registered.
- ROBwriteData  out  DATA_W  register-file write data, registered.
- count  out  TAG_W+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - head=tail=0, count=0, all valid/done bits 0, FSM=IDLE.
  - ROBwriteEnable=0, ROBwriteIndex=0, ROBwriteData=0.
  - Hence allocReady=1, empty=1, full=0, allocTag=0.
  - Reset overrides flush, alloc and CDB in the same cycle.
- Entry fields: valid, done, writesReg, dest[4:0], data[DATA_W-1:0].
- Allocation fires when allocValid && allocReady at an edge:
  - Entry[tail] is loaded with valid=1, done=0, writesReg and dest.
  - tail increments mod DEPTH.
  - allocReady is decoded from registered count only. A commit in the same cycle does not free a slot early.
- CDB capture, when cdbValid at an edge:
  - If entry[cdbTag].valid, set data=cdbData and done=1.
  - Otherwise ignore. This includes a tag being allocated in the same cycle.
  - A duplicate write to an already-done entry overwrites data.
- Commit FSM, two states:
  - IDLE:
    - If entry[head].valid && entry[head].done at the edge, pop head: clear valid, head+1 mod DEPTH, count-1.
    - If that entry has writesReg=1 and dest!=0: register ROBwriteIndex=dest, ROBwriteData=data, ROBwriteEnable=1, and go to PULSE.
    - Otherwise (writesReg=0, or dest==0) pop silently. ROBwriteEnable stays 0 and the FSM stays in IDLE. A further silent pop may occur on the next edge.
  - PULSE: at the next edge set ROBwriteEnable=0 and go to IDLE; no pop occurs. Index and data hold their last values.
  - Net rate: at most one register write every 2 cycles. Each write pulse is exactly 1 cycle wide.
- Latency:
  - The done bit is set at CDB edge M. The earliest pop is at edge M+1, so ROBwriteEnable is high in cycle M+1.
  - There is no CDB-to-commit bypass.
- count:
  - Increments on alloc only, decrements on pop only, and is unchanged when both happen.
  - count never exceeds DEPTH. The tail wraps from DEPTH-1 to 0.
- flush:
  - Clears all valid/done bits and sets head=tail=count=0.
  - Beats alloc, CDB and pop in the same cycle.
  - At that edge ROBwriteEnable goes to 0, and the FSM goes to IDLE even if it was in PULSE.
  - A pulse already driven in the flush cycle stands. This is a committed older instruction.
- Empty: the FSM stays in IDLE with no pop.
- Full: allocReady=0 and allocValid is ignored.

Test Plan:
- Basic commit:
  - Stimulus: reset; alloc dest=5, writesReg=1 (tag 0); next cycle CDB tag0 data=0xDEADBEEF.
  - Required: ROBwriteEnable high exactly 1 cycle, the cycle after the CDB edge, with Index=5, Data=0xDEADBEEF. count goes 1→0 and empty=1.
- Out-of-order completion:
  - Stimulus: alloc tags 0,1,2 with dest 1,2,3; CDB order tag2=0x30, tag0=0x10, tag1=0x20.
  - Required: writes appear in order reg1=0x10, reg2=0x20, reg3=0x30, each pulse separated by at least 1 low cycle.
- Silent commits:
  - Stimulus: alloc a store (writesReg=0), then dest=0 with writesReg=1, then dest=7; complete all three.
  - Required: exactly one pulse, Index=7. count reaches 0.
- Full and wrap:
  - Stimulus: alloc 8 entries.
  - Required: full=1, allocReady=0; a 9th alloc is ignored and count=8.
  - Then complete and commit tag0 and alloc one more.
  - Required: the new entry gets allocTag=0 (wrap) and count returns to 8.
- Flush mid-operation:
  - Stimulus: 4 entries allocated, tags 1 and 2 done, head tag0 not done; assert flush concurrently with a CDB tag0 write.
  - Required: count=0, empty=1, no ROBwriteEnable pulse afterwards.
  - A subsequent alloc returns tag 0.
- Reset mid-pulse:
  - Stimulus: deassert rst_n in the cycle ROBwriteEnable=1.
  - Required: at the next edge ROBwriteEnable=0, Index=0, Data=0, count=0.
  - A CDB write to a stale tag after reset causes no commit.

Source files
------------

// File: rtl/rob_commit_unit_if.sv
// rtl/rob_commit_unit_if.sv - dispatch, CDB, flush and register-file commit signals of the ROB
interface rob_commit_unit_if #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
);
  logic              allocValid;
  logic [4:0]        allocDest;
  logic              allocWritesReg;
  logic              allocReady;
  logic [TAG_W-1:0]  allocTag;
  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic              flush;
  logic              ROBwriteEnable;
  logic [4:0]        ROBwriteIndex;
  logic [DATA_W-1:0] ROBwriteData;
  logic [TAG_W:0]    count;
  logic              empty;
  logic              full;

  modport master (
    output allocValid, allocDest, allocWritesReg, cdbValid, cdbTag, cdbData, flush,
    input  allocReady, allocTag, ROBwriteEnable, ROBwriteIndex, ROBwriteData,
           count, empty, full
  );

  modport slave (
    input  allocValid, allocDest, allocWritesReg, cdbValid, cdbTag, cdbData, flush,
    output allocReady, allocTag, ROBwriteEnable, ROBwriteIndex, ROBwriteData,
           count, empty, full
  );
endinterface

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - circular reorder buffer retiring in order to a register-file write port
module rob_commit_unit #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  rob_commit_unit_if.slave rob
);
  typedef enum logic {IDLE, PULSE} state_e;

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, done_q, wreg_q;
  logic [4:0]        dest_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head_q, tail_q;
  logic [TAG_W:0]    count_q;
  logic              we_q;
  logic [4:0]        widx_q;
  logic [DATA_W-1:0] wdata_q;

  logic full_w, alloc_fire, cdb_hit, pop, commit_wr;

  always_comb begin
    full_w     = (count_q == FULL_CNT);
    alloc_fire = rob.allocValid && !full_w;
    cdb_hit    = rob.cdbValid && valid_q[rob.cdbTag];
    pop        = (state_q == IDLE) && valid_q[head_q] && done_q[head_q];
    commit_wr  = pop && wreg_q[head_q] && (dest_q[head_q] != 5'd0);
    state_d    = state_q;
    case (state_q)
      IDLE:    if (commit_wr) state_d = PULSE;
      PULSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rob.flush) state_d = IDLE;
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      wreg_q[tail_q] <= rob.allocWritesReg;
      dest_q[tail_q] <= rob.allocDest;
    end
    if (cdb_hit) data_q[rob.cdbTag] <= rob.cdbData;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (rob.flush) begin
        valid_q <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        we_q    <= 1'b0;
      end else begin
        if (cdb_hit) done_q[rob.cdbTag] <= 1'b1;
        if (alloc_fire) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          tail_q          <= tail_q + 1'b1;
        end
        if (pop) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        count_q <= count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, pop};
        // A pop is only possible from IDLE, so the strobe always drops after one cycle.
        we_q <= commit_wr;
        if (commit_wr) begin
          widx_q  <= dest_q[head_q];
          wdata_q <= data_q[head_q];
        end
      end
    end
  end

  assign rob.allocReady     = !full_w;
  assign rob.allocTag       = tail_q;
  assign rob.ROBwriteEnable = we_q;
  assign rob.ROBwriteIndex  = widx_q;
  assign rob.ROBwriteData   = wdata_q;
  assign rob.count          = count_q;
  assign rob.empty          = (count_q == '0);
  assign rob.full           = full_w;
endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - scoreboard bench for rob_commit_unit against an in-order queue model
module tb_rob_commit_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_commit_unit_if #(.DEPTH(8), .TAG_W(3), .DATA_W(32)) bus ();
  rob_commit_unit #(.DEPTH(8), .TAG_W(3), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .rob(bus));

  typedef struct {
    int          tag;
    logic [4:0]  dest;
    bit          wr;
    bit          done;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  ent_t rob_m[$];
  wr_t  expq[$];
  int   m_tail = 0;
  bit   m_pulse = 0;
  bit   m_we = 0;
  logic [4:0]  m_idx = '0;
  logic [31:0] m_data = '0;
  int total = 0;
  int bad = 0;
  bit prev_we = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: the queue front is the oldest instruction, and one
  // idle edge follows every register write.
  task automatic model_edge(input bit av, input logic [4:0] d, input bit wr, input bit cv,
                            input logic [2:0] ct, input logic [31:0] cd, input bit fl, input bit rn);
    bit do_pop;
    bit alloc_ok;
    ent_t head;
    if (!rn) begin
      rob_m.delete();
      m_tail = 0; m_pulse = 0; m_we = 0; m_idx = '0; m_data = '0;
    end else if (fl) begin
      rob_m.delete();
      m_tail = 0; m_pulse = 0; m_we = 0;
    end else begin
      alloc_ok = av && (rob_m.size() < 8);
      do_pop = !m_pulse && (rob_m.size() > 0) && rob_m[0].done;
      if (rob_m.size() > 0) head = rob_m[0];
      foreach (rob_m[i])
        if (cv && rob_m[i].tag == int'(ct)) begin
          rob_m[i].done = 1;
          rob_m[i].data = cd;
        end
      m_we = 0; m_pulse = 0;
      if (do_pop) begin
        void'(rob_m.pop_front());
        if (head.wr && head.dest != 5'd0) begin
          m_we = 1; m_pulse = 1; m_idx = head.dest; m_data = head.data;
          expq.push_back('{idx: head.dest, data: head.data});
        end
      end
      if (alloc_ok) begin
        rob_m.push_back('{tag: m_tail, dest: d, wr: wr, done: 0, data: '0});
        m_tail = (m_tail + 1) % 8;
      end
    end
  endtask

  task automatic cyc(input bit av, input logic [4:0] d, input bit wr, input bit cv,
                     input logic [2:0] ct, input logic [31:0] cd, input bit fl, input bit rn);
    bus.allocValid = av; bus.allocDest = d; bus.allocWritesReg = wr;
    bus.cdbValid = cv; bus.cdbTag = ct; bus.cdbData = cd;
    bus.flush = fl; rst_n = rn;
    @(posedge clk);
    model_edge(av, d, wr, cv, ct, cd, fl, rn);
    #1;
    chk("we", 32'(bus.ROBwriteEnable), 32'(m_we));
    chk("windex", 32'(bus.ROBwriteIndex), 32'(m_idx));
    chk("wdata", bus.ROBwriteData, m_data);
    chk("count", 32'(bus.count), 32'(rob_m.size()));
    chk("empty", 32'(bus.empty), 32'(rob_m.size() == 0));
    chk("full", 32'(bus.full), 32'(rob_m.size() == 8));
    chk("allocReady", 32'(bus.allocReady), 32'(rob_m.size() != 8));
    chk("allocTag", 32'(bus.allocTag), 32'(m_tail));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 1);
  endtask

  task automatic alloc(input logic [4:0] d, input bit wr);
    cyc(1, d, wr, 0, 3'd0, 32'd0, 0, 1);
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] v);
    cyc(0, 5'd0, 0, 1, t, v, 0, 1);
  endtask

  task automatic do_flush();
    cyc(0, 5'd0, 0, 0, 3'd0, 32'd0, 1, 1);
  endtask

  // Monitor: each strobe must match the oldest outstanding write and be isolated.
  always @(posedge clk) begin
    #1;
    if (bus.ROBwriteEnable === 1'b1) begin
      chk("pulse_gap", 32'(prev_we), 32'd0);
      if (expq.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = expq.pop_front();
        chk("sb_index", 32'(bus.ROBwriteIndex), 32'(e.idx));
        chk("sb_data", bus.ROBwriteData, e.data);
      end
    end
    prev_we = (bus.ROBwriteEnable === 1'b1);
  end

  initial begin
    bus.allocValid = 0; bus.allocDest = '0; bus.allocWritesReg = 0;
    bus.cdbValid = 0; bus.cdbTag = '0; bus.cdbData = '0; bus.flush = 0;
    cyc(0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 0);
    cyc(1, 5'd3, 1, 1, 3'd0, 32'd1, 1, 0);

    alloc(5'd5, 1);
    cdb(3'd0, 32'hDEADBEEF);
    idle(3);

    do_flush();
    alloc(5'd1, 1); alloc(5'd2, 1); alloc(5'd3, 1);
    cdb(3'd2, 32'h30); cdb(3'd0, 32'h10); cdb(3'd1, 32'h20);
    idle(8);

    do_flush();
    alloc(5'd4, 0); alloc(5'd0, 1); alloc(5'd7, 1);
    cdb(3'd0, 32'hA); cdb(3'd1, 32'hB); cdb(3'd2, 32'h77);
    idle(6);

    do_flush();
    for (int i = 0; i < 9; i++) alloc(5'(i + 1), 1);
    cdb(3'd0, 32'h99);
    idle(1);
    alloc(5'd20, 1);
    idle(2);

    do_flush();
    for (int i = 0; i < 4; i++) alloc(5'(i + 10), 1);
    cdb(3'd1, 32'h11); cdb(3'd2, 32'h22);
    cyc(0, 5'd0, 0, 1, 3'd0, 32'h33, 1, 1);
    idle(3);
    alloc(5'd6, 1);
    idle(1);

    do_flush();
    alloc(5'd9, 1);
    cdb(3'd0, 32'h55);
    idle(1);
    cyc(0, 5'd0, 0, 0, 3'd0, 32'd0, 0, 0);
    cdb(3'd0, 32'h66);
    idle(3);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 45, 5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 63) == 0, $urandom_range(0, 255) != 0);
    end
    idle(4);
    chk("scoreboard_drain", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
